// File: rtl/wbc_pkg.sv
// rtl/wbc_pkg.sv - shared slot/error types and beat-slice helper for wr_beat_scoreboard
package wbc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    LINGER = 2'd2
  } slot_state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_DATA     = 3'd1,
    ERR_OVERFLOW = 3'd2,
    ERR_ORPHAN   = 3'd3,
    ERR_REUSE    = 3'd4
  } err_e;

  // Widest payload and beat the helper handles; callers zero-extend into these.
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BEAT_W = 64;

  // Beat number idx of a payload made of beat_w-bit beats, beat 0 in the LSBs.
  function automatic logic [MAX_BEAT_W-1:0] beat_slice(
    input logic [MAX_DATA_W-1:0] payload,
    input int                    beat_w,
    input int                    idx
  );
    logic [MAX_BEAT_W-1:0] mask;
    for (int i = 0; i < MAX_BEAT_W; i++) begin
      mask[i] = (i < beat_w);
    end
    return MAX_BEAT_W'(payload >> (beat_w * idx)) & mask;
  endfunction

endpackage

// File: rtl/wr_beat_scoreboard_if.sv
// rtl/wr_beat_scoreboard_if.sv - tagged write-data protocol bundle observed by wr_beat_scoreboard
interface wr_beat_scoreboard_if #(
  parameter int TAG_W  = 4,
  parameter int BEAT_W = 8,
  parameter int BEATS  = 16
);

  logic                    write_request;
  logic                    write_request_ack;
  logic [TAG_W-1:0]        write_request_ack_tag;
  logic [BEAT_W*BEATS-1:0] model_data;
  logic                    data_valid;
  logic [TAG_W-1:0]        data_valid_tag;
  logic [BEAT_W-1:0]       data;
  logic                    last_data_valid;
  logic                    retry;
  logic [TAG_W-1:0]        retry_tag;

  modport master (
    output write_request, write_request_ack, write_request_ack_tag, model_data,
    output data_valid, data_valid_tag, data, last_data_valid,
    output retry, retry_tag
  );

  modport slave (
    input write_request, write_request_ack, write_request_ack_tag, model_data,
    input data_valid, data_valid_tag, data, last_data_valid,
    input retry, retry_tag
  );

endinterface

// File: rtl/wbc_slot.sv
// rtl/wbc_slot.sv - one tag's FSM, expected payload, beat index and compare (stats flags under WR_BEAT_SCOREBOARD_STATS_EN)
module wbc_slot
  import wbc_pkg::*;
#(
  parameter int BEAT_W = 8,
  parameter int BEATS  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     accept,
  input  logic [BEAT_W*BEATS-1:0]  model_data,
  input  logic                     beat,
  input  logic                     last,
  input  logic [BEAT_W-1:0]        data,
  input  logic                     retry,
  output logic [$clog2(BEATS)-1:0] index,
  output logic                     busy_next,
  output logic                     err_data,
  output logic                     err_overflow,
  output logic                     err_orphan,
  output logic                     err_reuse
`ifdef WR_BEAT_SCOREBOARD_STATS_EN
  ,
  output logic                     done,
  output logic                     retry_applied
`endif
);

  localparam int DATA_W = BEAT_W * BEATS;
  localparam int IDX_W  = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  slot_state_e           state;
  slot_state_e           state_d;
  logic [DATA_W-1:0]     payload;
  logic [DATA_W-1:0]     payload_d;
  logic [IDX_W-1:0]      index_d;
  logic [MAX_DATA_W-1:0] payload_wide;
  logic [MAX_BEAT_W-1:0] data_wide;
  logic [MAX_BEAT_W-1:0] exp_wide;

  // Expected beat at the current index, compared at the helper's fixed width
  always_comb begin
    payload_wide               = '0;
    payload_wide[DATA_W-1:0]   = payload;
    data_wide                  = '0;
    data_wide[BEAT_W-1:0]      = data;
    exp_wide                   = beat_slice(payload_wide, BEAT_W, int'(index));
  end

  // Beat is judged on the current state, then retry rewinds, then acceptance overwrites
  always_comb begin
    state_d      = state;
    index_d      = index;
    payload_d    = payload;
    err_data     = 1'b0;
    err_overflow = 1'b0;
    err_orphan   = 1'b0;
    err_reuse    = 1'b0;

    if (beat) begin
      if (state == ACTIVE) begin
        err_data = (data_wide != exp_wide);
        if (last) begin
          state_d = LINGER;
        end else if (index == LAST_IDX) begin
          // Index saturates so later beats keep comparing against the final slice
          err_overflow = 1'b1;
        end else begin
          index_d = index + 1'b1;
        end
      end else begin
        err_orphan = 1'b1;
      end
    end

    if (state == LINGER) begin
      // The post-last window is a single cycle: a retry revives the slot, else it frees
      state_d = retry ? ACTIVE : IDLE;
      index_d = '0;
    end else if (state == ACTIVE && retry) begin
      state_d = ACTIVE;
      index_d = '0;
    end

    if (accept) begin
      err_reuse = (state == ACTIVE);
      state_d   = ACTIVE;
      index_d   = '0;
      payload_d = model_data;
    end
  end

  assign busy_next = (state_d != IDLE);

`ifdef WR_BEAT_SCOREBOARD_STATS_EN
  assign done          = (state == LINGER) && !retry && !accept;
  assign retry_applied = retry && (state != IDLE);
`endif

  // Slot state, beat index and captured payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      index   <= '0;
      payload <= '0;
    end else begin
      state   <= state_d;
      index   <= index_d;
      payload <= payload_d;
    end
  end

endmodule

// File: rtl/wr_beat_scoreboard.sv
// rtl/wr_beat_scoreboard.sv - tagged write-data checker top; optional counters under WR_BEAT_SCOREBOARD_STATS_EN
module wr_beat_scoreboard
  import wbc_pkg::*;
#(
  parameter int TAG_W  = 4,
  parameter int BEAT_W = 8,
  parameter int BEATS  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  wr_beat_scoreboard_if.slave      bus,
  output logic                     err_valid,
  output err_e                     err_code,
  output logic [TAG_W-1:0]         err_tag,
  output logic [$clog2(BEATS)-1:0] err_beat,
  output logic                     err_multi,
  output logic [TAG_W:0]           outstanding,
  output logic                     busy
`ifdef WR_BEAT_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]              stat_done,
  output logic [31:0]              stat_retry,
  output logic [31:0]              stat_err
`endif
);

  localparam int NUM_TAGS = 2 ** TAG_W;
  localparam int IDX_W    = $clog2(BEATS);

  logic                accepted;
  logic [NUM_TAGS-1:0] acc_sel;
  logic [NUM_TAGS-1:0] beat_sel;
  logic [NUM_TAGS-1:0] retry_sel;
  logic [NUM_TAGS-1:0] busy_next;
  logic [NUM_TAGS-1:0] e_data;
  logic [NUM_TAGS-1:0] e_ovf;
  logic [NUM_TAGS-1:0] e_orph;
  logic [NUM_TAGS-1:0] e_reuse;
  logic [IDX_W-1:0]    slot_index [NUM_TAGS];

  logic                beat_err;
  logic                err_valid_d;
  err_e                code_d;
  logic [TAG_W-1:0]    tag_d;
  logic [IDX_W-1:0]    beat_d;
  logic                multi_d;
  logic [TAG_W:0]      cnt_d;

  assign accepted = bus.write_request & bus.write_request_ack;

  // One-hot decode of the acceptance, beat and retry tags
  always_comb begin
    acc_sel                            = '0;
    beat_sel                           = '0;
    retry_sel                          = '0;
    acc_sel[bus.write_request_ack_tag] = accepted;
    beat_sel[bus.data_valid_tag]       = bus.data_valid;
    retry_sel[bus.retry_tag]           = bus.retry;
  end

`ifdef WR_BEAT_SCOREBOARD_STATS_EN
  logic [NUM_TAGS-1:0] done_v;
  logic [NUM_TAGS-1:0] retry_v;
`endif

  for (genvar t = 0; t < NUM_TAGS; t++) begin : g_slot
    wbc_slot #(
      .BEAT_W (BEAT_W),
      .BEATS  (BEATS)
    ) u_slot (
      .clk           (clk),
      .rst_n         (rst_n),
      .accept        (acc_sel[t]),
      .model_data    (bus.model_data),
      .beat          (beat_sel[t]),
      .last          (bus.last_data_valid),
      .data          (bus.data),
      .retry         (retry_sel[t]),
      .index         (slot_index[t]),
      .busy_next     (busy_next[t]),
      .err_data      (e_data[t]),
      .err_overflow  (e_ovf[t]),
      .err_orphan    (e_orph[t]),
      .err_reuse     (e_reuse[t])
`ifdef WR_BEAT_SCOREBOARD_STATS_EN
      ,
      .done          (done_v[t]),
      .retry_applied (retry_v[t])
`endif
    );
  end

  // Only the beat's slot can raise beat errors and only the accepted slot can raise reuse,
  // so OR-reduction identifies the source and the tag buses locate it
  always_comb begin
    beat_err = (|e_data) | (|e_ovf) | (|e_orph);
    code_d   = ERR_NONE;
    tag_d    = '0;
    beat_d   = '0;
    if (|e_data) begin
      code_d = ERR_DATA;
      tag_d  = bus.data_valid_tag;
      beat_d = slot_index[bus.data_valid_tag];
    end else if (|e_ovf) begin
      code_d = ERR_OVERFLOW;
      tag_d  = bus.data_valid_tag;
      beat_d = slot_index[bus.data_valid_tag];
    end else if (|e_orph) begin
      code_d = ERR_ORPHAN;
      tag_d  = bus.data_valid_tag;
      beat_d = slot_index[bus.data_valid_tag];
    end else if (|e_reuse) begin
      code_d = ERR_REUSE;
      tag_d  = bus.write_request_ack_tag;
      beat_d = slot_index[bus.write_request_ack_tag];
    end
    err_valid_d = (code_d != ERR_NONE);
    multi_d     = beat_err & (|e_reuse);
  end

  // Popcount of slots that will be non-idle after this edge
  always_comb begin
    cnt_d = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      cnt_d = cnt_d + (TAG_W + 1)'(busy_next[t]);
    end
  end

  // Registered error report and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid   <= 1'b0;
      err_code    <= ERR_NONE;
      err_tag     <= '0;
      err_beat    <= '0;
      err_multi   <= 1'b0;
      outstanding <= '0;
      busy        <= 1'b0;
    end else begin
      err_valid   <= err_valid_d;
      err_code    <= code_d;
      err_tag     <= tag_d;
      err_beat    <= beat_d;
      err_multi   <= multi_d;
      outstanding <= cnt_d;
      busy        <= |busy_next;
    end
  end

`ifdef WR_BEAT_SCOREBOARD_STATS_EN
  // Saturating event counters; at most one done and one retry can occur per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_done  <= '0;
      stat_retry <= '0;
      stat_err   <= '0;
    end else begin
      if ((|done_v) && (stat_done != '1)) begin
        stat_done <= stat_done + 32'd1;
      end
      if ((|retry_v) && (stat_retry != '1)) begin
        stat_retry <= stat_retry + 32'd1;
      end
      if (err_valid_d && (stat_err != '1)) begin
        stat_err <= stat_err + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wr_beat_scoreboard.sv
// tb/tb_wr_beat_scoreboard.sv - directed scoreboard bench for wr_beat_scoreboard
`timescale 1ns/1ps
module tb_wr_beat_scoreboard;

  localparam int TAG_W  = 4;
  localparam int BEAT_W = 8;
  localparam int BEATS  = 16;
  localparam int IDX_W  = 4;
  localparam int DATA_W = BEAT_W * BEATS;

  localparam int C_DATA     = 1;
  localparam int C_OVERFLOW = 2;
  localparam int C_ORPHAN   = 3;
  localparam int C_REUSE    = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wr_beat_scoreboard_if #(.TAG_W(TAG_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) bus ();

  logic             err_valid;
  logic [2:0]       err_code;
  logic [TAG_W-1:0] err_tag;
  logic [IDX_W-1:0] err_beat;
  logic             err_multi;
  logic [TAG_W:0]   outstanding;
  logic             busy;
`ifdef WR_BEAT_SCOREBOARD_STATS_EN
  logic [31:0]      stat_done;
  logic [31:0]      stat_retry;
  logic [31:0]      stat_err;
`endif

  wr_beat_scoreboard #(.TAG_W(TAG_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .err_tag     (err_tag),
    .err_beat    (err_beat),
    .err_multi   (err_multi),
    .outstanding (outstanding),
    .busy        (busy)
`ifdef WR_BEAT_SCOREBOARD_STATS_EN
    ,
    .stat_done   (stat_done),
    .stat_retry  (stat_retry),
    .stat_err    (stat_err)
`endif
  );

  typedef struct {
    int due;
    int code;
    int tag;
    int beat;
    int multi;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every err_valid pulse must match the oldest expected error due this cycle
  always @(negedge clk) begin
    if (err_valid) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        mon_e = exp_q.pop_front();
        n_vec++;
        if (int'(err_code) != mon_e.code || int'(err_tag) != mon_e.tag ||
            int'(err_beat) != mon_e.beat || int'(err_multi) != mon_e.multi) begin
          n_fail++;
          $display("FAIL err_report cyc=%0d got code=%0d tag=%0d beat=%0d multi=%0d want code=%0d tag=%0d beat=%0d multi=%0d",
                   cyc, err_code, err_tag, err_beat, err_multi,
                   mon_e.code, mon_e.tag, mon_e.beat, mon_e.multi);
        end
      end else begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_err cyc=%0d got code=%0d tag=%0d beat=%0d want no error",
                 cyc, err_code, err_tag, err_beat);
      end
    end
    while (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL missing_err cyc=%0d got err_valid=0 want code=%0d tag=%0d beat=%0d",
               cyc, mon_e.code, mon_e.tag, mon_e.beat);
    end
  end

  function automatic logic [DATA_W-1:0] seq_payload();
    logic [DATA_W-1:0] p;
    for (int i = 0; i < BEATS; i++) p[i*BEAT_W +: BEAT_W] = 8'(i);
    return p;
  endfunction

  task automatic clear_in();
    bus.write_request         = 1'b0;
    bus.write_request_ack     = 1'b0;
    bus.write_request_ack_tag = '0;
    bus.model_data            = '0;
    bus.data_valid            = 1'b0;
    bus.data_valid_tag        = '0;
    bus.data                  = '0;
    bus.last_data_valid       = 1'b0;
    bus.retry                 = 1'b0;
    bus.retry_tag             = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic set_accept(input int tag);
    bus.write_request         = 1'b1;
    bus.write_request_ack     = 1'b1;
    bus.write_request_ack_tag = TAG_W'(tag);
    bus.model_data            = seq_payload();
  endtask

  task automatic set_beat(input int tag, input int d, input bit last);
    bus.data_valid      = 1'b1;
    bus.data_valid_tag  = TAG_W'(tag);
    bus.data            = BEAT_W'(d);
    bus.last_data_valid = last;
  endtask

  task automatic set_retry(input int tag);
    bus.retry     = 1'b1;
    bus.retry_tag = TAG_W'(tag);
  endtask

  task automatic expect_err(input int code, input int tag, input int beat, input int multi);
    exp_q.push_back('{cyc + 1, code, tag, beat, multi});
  endtask

  task automatic check(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  // Matching beats first..last_i on a tag; last flag on the final one if requested
  task automatic beats(input int tag, input int first, input int last_i, input bit end_last);
    for (int k = first; k <= last_i; k++) begin
      set_beat(tag, k, end_last && (k == last_i));
      cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    repeat (3) @(posedge clk);
    #1;
    check("rst_err_valid", int'(err_valid), 0);
    check("rst_err_code", int'(err_code), 0);
    check("rst_err_tag", int'(err_tag), 0);
    check("rst_err_beat", int'(err_beat), 0);
    check("rst_err_multi", int'(err_multi), 0);
    check("rst_outstanding", int'(outstanding), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    cycle();

    // Clean 16-beat transfer on tag 3
    set_accept(3);
    cycle();
    check("t3_outstanding_active", int'(outstanding), 1);
    check("t3_busy_active", int'(busy), 1);
    beats(3, 0, 15, 1'b1);
    check("t3_outstanding_linger", int'(outstanding), 1);
    cycle();
    check("t3_outstanding_done", int'(outstanding), 0);
    check("t3_busy_done", int'(busy), 0);

    // Data mismatch on tag 5 beat 2
    set_accept(5);
    cycle();
    beats(5, 0, 1, 1'b0);
    set_beat(5, 'hAA, 1'b0);
    expect_err(C_DATA, 5, 2, 0);
    cycle();
    beats(5, 3, 15, 1'b1);
    cycle();

    // Retry rewinds on tag 7, including the linger window and beat+retry together
    set_accept(7);
    cycle();
    beats(7, 0, 3, 1'b0);
    set_retry(7);
    cycle();
    beats(7, 0, 15, 1'b1);
    set_retry(7);
    cycle();
    check("t7_outstanding_relinger", int'(outstanding), 1);
    cycle();
    check("t7_outstanding_held", int'(outstanding), 1);
    beats(7, 0, 14, 1'b0);
    set_beat(7, 15, 1'b1);
    set_retry(7);
    cycle();
    cycle();
    check("t7_outstanding_beat_retry", int'(outstanding), 1);
    beats(7, 0, 15, 1'b1);
    cycle();
    check("t7_outstanding_done", int'(outstanding), 0);

    // Orphan beat on idle tag 9 with reuse on tag 3 in the same cycle
    set_accept(3);
    cycle();
    set_beat(9, 0, 1'b0);
    set_accept(3);
    expect_err(C_ORPHAN, 9, 0, 1);
    cycle();

    // Fill every slot, interleave beats, then reset mid-stream
    for (int t = 0; t < 16; t++) begin
      set_accept(t);
      if (t == 3) expect_err(C_REUSE, 3, 0, 0);
      cycle();
    end
    check("all_outstanding_full", int'(outstanding), 16);
    check("all_busy", int'(busy), 1);
    for (int t = 0; t < 16; t++) begin
      set_beat(t, 0, 1'b0);
      cycle();
    end
    for (int t = 0; t < 16; t += 2) begin
      set_beat(t, 1, 1'b0);
      cycle();
    end
    check("all_outstanding_interleaved", int'(outstanding), 16);
    rst_n = 1'b0;
    #1;
    check("midrst_err_valid", int'(err_valid), 0);
    check("midrst_err_code", int'(err_code), 0);
    check("midrst_outstanding", int'(outstanding), 0);
    check("midrst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_beat(4, 4, 1'b0);
    expect_err(C_ORPHAN, 4, 0, 0);
    cycle();
    check("postrst_outstanding", int'(outstanding), 0);

    // Acceptance during the linger cycle is legal
    set_accept(2);
    cycle();
    beats(2, 0, 15, 1'b1);
    set_accept(2);
    cycle();
    cycle();
    check("t2_outstanding_reaccept", int'(outstanding), 1);
    set_beat(2, 0, 1'b0);
    cycle();

    // Seventeen non-last beats on tag 1: index saturates at 15
    set_accept(1);
    cycle();
    for (int k = 0; k < 17; k++) begin
      set_beat(1, (k > 15) ? 15 : k, 1'b0);
      if (k >= 15) expect_err(C_OVERFLOW, 1, 15, 0);
      cycle();
    end
    check("t1_outstanding_overflow", int'(outstanding), 2);

    repeat (3) cycle();
    check("exp_queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
